t05_sram_arbiter: RTL and testbench

- Single-port SRAM access sequencer and arbiter for the team_05 Huffman pipeline.
- Requesters: histogram, find-least-value (FLV), htree, codebook, translation.
- Each requester gets a simple req/ack word-access interface. The block round-robins between them, adds the per-client region base address, and runs the SRAM bus handshake (wr_en/r_en pulse, busy_o wait, data capture).

---
 rtl/t05_sram_pkg.sv | 40 ++++
 rtl/t05_rr_picker.sv | 30 +++
 rtl/t05_sram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_t05_sram_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/t05_sram_pkg.sv
// Shared types and constants for the team_05 SRAM arbiter: client ids, FSM states,
// per-client region bases and the watchdog fill word.
package t05_sram_pkg;

  typedef enum logic [2:0] {
    CL_HIST     = 3'd0,
    CL_FLV      = 3'd1,
    CL_HTREE    = 3'd2,
    CL_CODEBOOK = 3'd3,
    CL_TRN      = 3'd4
  } cl_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StIssue  = 3'd1,
    StSettle = 3'd2,
    StWait   = 3'd3,
    StDone   = 3'd4
  } arb_state_e;

  localparam logic [31:0] BaseHist     = 32'h000;
  localparam logic [31:0] BaseFlv      = 32'h000;
  localparam logic [31:0] BaseHtree    = 32'h400;
  localparam logic [31:0] BaseCodebook = 32'h800;
  localparam logic [31:0] BaseTrn      = 32'h800;

  localparam logic [31:0] TimeoutFill = 32'hDEAD_BEEF;

  function automatic logic [31:0] base_addr(input logic [2:0] cl);
    case (cl)
      CL_HIST:     return BaseHist;
      CL_FLV:      return BaseFlv;
      CL_HTREE:    return BaseHtree;
      CL_CODEBOOK: return BaseCodebook;
      CL_TRN:      return BaseTrn;
      default:     return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/t05_rr_picker.sv
// Combinational round-robin picker: first set bit of eligible_i at or after ptr_i, wrapping.
module t05_rr_picker #(
  parameter int unsigned NumCl = 5,
  parameter int unsigned PtrW  = 3
) (
  input  logic [NumCl-1:0] eligible_i,
  input  logic [PtrW-1:0]  ptr_i,
  output logic [PtrW-1:0]  grant_o,
  output logic             valid_o
);

  logic [31:0]     sum;
  logic [PtrW-1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    grant_o = '0;
    sum     = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NumCl; i++) begin
      sum  = 32'(ptr_i) + i;
      cand = PtrW'(sum % NumCl);
      if (!valid_o && eligible_i[cand]) begin
        valid_o = 1'b1;
        grant_o = cand;
      end
    end
  end

endmodule

// File: rtl/t05_sram_arbiter.sv
// Round-robin single-port SRAM sequencer for the Huffman pipeline clients.
// Optional watchdog on the WAIT phase: define T05_SRAM_ARB_TIMEOUT_EN.
module t05_sram_arbiter
  import t05_sram_pkg::*;
#(
  parameter int unsigned NUM_CL      = 5,
  parameter int unsigned IDX_W       = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CL-1:0]          cl_en,
  input  logic [NUM_CL-1:0]          cl_req,
  input  logic [NUM_CL-1:0]          cl_we,
  input  logic [NUM_CL*IDX_W-1:0]    cl_idx,
  input  logic [NUM_CL*DATA_W-1:0]   cl_wdata,
  output logic [NUM_CL-1:0]          cl_ack,
  output logic [DATA_W-1:0]          cl_rdata,
  output logic                       busy,
  output logic                       wr_en,
  output logic                       r_en,
  output logic [3:0]                 select,
  output logic [31:0]                addr,
  output logic [31:0]                sram_data_in,
  input  logic [31:0]                sram_data_out,
  input  logic                       busy_o,
  output logic                       err
);

  localparam int unsigned PtrW = (NUM_CL > 1) ? $clog2(NUM_CL) : 1;

  // The watchdog counter is 8 bits wide.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..255");
  end

  arb_state_e        state_q, state_d;
  logic [PtrW-1:0]   ptr_q, g_q, pick_idx;
  logic              pick_valid, grant_fire, we_q, tmo_hit;
  logic [NUM_CL-1:0] eligible;
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] sel_wdata, rdata_q;
  logic [31:0]       addr_q, din_q;
  logic [3:0]        sel_q;

  assign eligible   = cl_req & cl_en;
  assign grant_fire = (state_q == StIdle) && pick_valid;

  t05_rr_picker #(
    .NumCl (NUM_CL),
    .PtrW  (PtrW)
  ) u_picker (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (pick_idx),
    .valid_o    (pick_valid)
  );

  always_comb begin
    sel_idx   = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_CL; i++) begin
      if (32'(pick_idx) == i) begin
        sel_idx   = cl_idx[i*IDX_W +: IDX_W];
        sel_wdata = cl_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != StIdle);
    wr_en   = 1'b0;
    r_en    = 1'b0;
    cl_ack  = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) state_d = StIssue;
      end
      StIssue: begin
        wr_en   = we_q;
        r_en    = !we_q;
        state_d = StSettle;
      end
      // busy_o can lag the strobe by a cycle, so it is not looked at here.
      StSettle: state_d = StWait;
      StWait: begin
        if (!busy_o || tmo_hit) state_d = StDone;
      end
      StDone: begin
        for (int unsigned i = 0; i < NUM_CL; i++) begin
          cl_ack[i] = (32'(g_q) == i);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus-side registers load at grant so they are valid for the whole ISSUE cycle
  // and hold until the next grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q   <= '0;
      g_q     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      din_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (grant_fire) begin
        g_q    <= pick_idx;
        we_q   <= cl_we[pick_idx];
        addr_q <= base_addr(3'(pick_idx)) + (32'(sel_idx) << 2);
        sel_q  <= 4'b1111;
        if (cl_we[pick_idx]) din_q <= 32'(sel_wdata);
      end
      if (state_q == StWait && !we_q) begin
        if (!busy_o) begin
          rdata_q <= DATA_W'(sram_data_out);
        end else if (tmo_hit) begin
          rdata_q <= DATA_W'(TimeoutFill);
        end
      end
      if (state_q == StDone) begin
        ptr_q <= (32'(g_q) == NUM_CL - 1) ? '0 : g_q + PtrW'(1);
      end
    end
  end

  assign addr         = addr_q;
  assign select       = sel_q;
  assign sram_data_in = din_q;
  assign cl_rdata     = rdata_q;

`ifdef T05_SRAM_ARB_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_q;
  logic       err_q;

  // Fires in the WAIT cycle whose increment would bring the count to TIMEOUT_CYC.
  assign tmo_hit = busy_o && (cnt_q == TmoLast);
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        cnt_q <= '0;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (state_q == StWait && tmo_hit) err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// Randomized bench for t05_sram_arbiter against a transaction-timeline reference model.
module tb_t05_sram_arbiter;

  localparam int NCL  = 5;
  localparam int IW   = 9;
  localparam int DW   = 32;
  localparam int NCYC = 3000;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCL-1:0]    cl_en, cl_req, cl_we, cl_ack;
  logic [NCL*IW-1:0] cl_idx;
  logic [NCL*DW-1:0] cl_wdata;
  logic [DW-1:0]     cl_rdata;
  logic              busy, wr_en, r_en, busy_o, err;
  logic [3:0]        select;
  logic [31:0]       addr, sram_data_in, sram_data_out;

  always #5 clk = ~clk;

  t05_sram_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .cl_en         (cl_en),
    .cl_req        (cl_req),
    .cl_we         (cl_we),
    .cl_idx        (cl_idx),
    .cl_wdata      (cl_wdata),
    .cl_ack        (cl_ack),
    .cl_rdata      (cl_rdata),
    .busy          (busy),
    .wr_en         (wr_en),
    .r_en          (r_en),
    .select        (select),
    .addr          (addr),
    .sram_data_in  (sram_data_in),
    .sram_data_out (sram_data_out),
    .busy_o        (busy_o),
    .err           (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Region bases per client, straight from the memory map.
  logic [31:0] base_tbl [NCL] = '{32'h000, 32'h000, 32'h400, 32'h800, 32'h800};

  logic [IW-1:0] c_idx [NCL];
  logic [DW-1:0] c_wd  [NCL];

  // Reference model: one outstanding transaction described by its grant cycle and stall.
  bit          tx_active;
  int          tx_g, tx_gc, tx_s, ptr;
  bit          tx_we;
  logic [31:0] tx_addr, tx_wdata, tx_rdata;
  logic [31:0] m_addr, m_din, m_rdata;
  logic [3:0]  m_sel;
  logic [4:0]  exp_ack, elig;
  bit          ack_now, found;
  int          j, k_lat;

  task automatic pack_clients();
    for (int i = 0; i < NCL; i++) begin
      cl_idx[i*IW +: IW]   = c_idx[i];
      cl_wdata[i*DW +: DW] = c_wd[i];
    end
  endtask

  initial begin
    rst = 1'b0; cl_en = '1; cl_req = '0; cl_we = '0;
    busy_o = 1'b0; sram_data_out = '0;
    for (int i = 0; i < NCL; i++) begin c_idx[i] = '0; c_wd[i] = '0; end
    pack_clients();
    tx_active = 0; ptr = 0;
    m_addr = '0; m_din = '0; m_rdata = '0; m_sel = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int c = 0; c < NCYC; c++) begin
      // Model-visible register updates for this cycle.
      if (tx_active && c == tx_gc + 1) begin
        m_addr = tx_addr;
        m_sel  = 4'hF;
        if (tx_we) m_din = tx_wdata;
      end
      if (tx_active && c == tx_gc + 4 + tx_s && !tx_we) m_rdata = tx_rdata;

      exp_ack = (tx_active && c == tx_gc + 4 + tx_s) ? (5'b1 << tx_g) : 5'b0;
      ack_now = (exp_ack != 0);
      check_eq("ack",    cl_ack, exp_ack);
      check_eq("busy",   busy, tx_active && c >= tx_gc + 1 && c <= tx_gc + 4 + tx_s);
      check_eq("r_en",   r_en, tx_active && c == tx_gc + 1 && !tx_we);
      check_eq("wr_en",  wr_en, tx_active && c == tx_gc + 1 && tx_we);
      check_eq("addr",   addr, m_addr);
      check_eq("select", select, m_sel);
      check_eq("wdata",  sram_data_in, m_din);
      check_eq("rdata",  cl_rdata, m_rdata);
      check_eq("err",    err, 0);

      // Stimulus for this cycle.
      rst = 1'b1;
      if (c < 2) rst = 1'b0;
      else if (tx_active && c >= tx_gc + 3 && c < tx_gc + 3 + tx_s &&
               $urandom_range(0, 15) == 0) rst = 1'b0;

      for (int i = 0; i < NCL; i++) begin
        if (ack_now && i == tx_g) begin
          cl_req[i] = 1'b0;
        end else if (!cl_req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            cl_req[i] = 1'b1;
            cl_we[i]  = 1'($urandom);
            c_idx[i]  = IW'($urandom);
            c_wd[i]   = $urandom;
          end
        end else if (tx_active && i == tx_g) begin
          // Granted already: inputs may wander or drop without affecting the access.
          if ($urandom_range(0, 7) == 0) cl_req[i] = 1'b0;
          cl_we[i] = 1'($urandom);
          c_idx[i] = IW'($urandom);
          c_wd[i]  = $urandom;
        end
      end
      pack_clients();
      if ($urandom_range(0, 15) == 0) begin
        j = $urandom_range(0, NCL - 1);
        cl_en[j] = ~cl_en[j];
      end

      if (tx_active && c >= tx_gc + 3 && c < tx_gc + 3 + tx_s) busy_o = 1'b1;
      else if (tx_active && c == tx_gc + 3 + tx_s) busy_o = 1'b0;
      else busy_o = 1'($urandom);
      sram_data_out = $urandom;
      if (tx_active && c == tx_gc + 3 + tx_s) tx_rdata = sram_data_out;

      if (ack_now) begin
        ptr       = (tx_g + 1) % NCL;
        tx_active = 0;
      end

      if (!rst) begin
        tx_active = 0; ptr = 0;
        m_addr = '0; m_din = '0; m_rdata = '0; m_sel = '0;
      end else if (!tx_active && !ack_now) begin
        elig  = cl_req & cl_en;
        found = 0;
        for (int k = 0; k < NCL; k++) begin
          j = (ptr + k) % NCL;
          if (!found && elig[j]) begin found = 1; tx_g = j; end
        end
        if (found) begin
          tx_active = 1;
          tx_gc     = c;
          tx_we     = cl_we[tx_g];
          tx_addr   = base_tbl[tx_g] + 32'(c_idx[tx_g]) * 4;
          tx_wdata  = c_wd[tx_g];
          tx_s      = ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 2);
        end
      end

      @(posedge clk);
      #1;
    end

`ifdef T05_SRAM_ARB_TIMEOUT_EN
    rst = 1'b0; cl_req = '0;
    @(posedge clk);
    #1;
    rst = 1'b1; cl_en = '1; cl_req = 5'b00010; cl_we = '0; busy_o = 1'b1;
    k_lat = 0;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk);
      #1;
      k_lat = k;
      if (cl_ack != 0) break;
    end
    check_eq("tmo_latency", k_lat, 258);
    check_eq("tmo_ack",     cl_ack, 5'b00010);
    check_eq("tmo_err",     err, 1);
    check_eq("tmo_rdata",   cl_rdata, 32'hDEADBEEF);
    cl_req = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("tmo_sticky", err, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("tmo_clear", err, 0);
    rst = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
